// File: rtl/onehot_pkg.sv
// Shared definitions for one-hot consumers: default widths, skid FSM state
// type and a lowest-set-bit helper.
package onehot_pkg;

  localparam int ONEHOT_W = 16;
  localparam int BIN_W    = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } dec_state_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [BIN_W-1:0] lowest_set_idx(input logic [ONEHOT_W-1:0] v);
    logic [BIN_W-1:0] idx;
    idx = '0;
    for (int i = ONEHOT_W - 1; i >= 0; i--) begin
      if (v[i]) idx = BIN_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/onehot_dec_core.sv
// Combinational one-hot to binary decode with an illegal-pattern flag
// (zero bits or more than one bit set).
module onehot_dec_core
  import onehot_pkg::*;
#(
  parameter int ONEHOT_WIDTH = ONEHOT_W,
  parameter int BIN_WIDTH    = BIN_W
) (
  input  logic [ONEHOT_WIDTH-1:0] onehot_i,
  output logic [BIN_WIDTH-1:0]    bin_o,
  output logic                    err_o
);

  logic multi_bit;

  assign bin_o     = BIN_WIDTH'(lowest_set_idx(ONEHOT_W'(onehot_i)));
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_bit = (onehot_i & (onehot_i - ONEHOT_WIDTH'(1))) != '0;
  assign err_o     = (onehot_i == '0) || multi_bit;

endmodule

// File: rtl/onehot_dec_skid.sv
// One-hot decoder behind a registered 2-entry skid stage with a saturating
// illegal-word counter. Define ONEHOT_DEC_STRICT_EN to drop illegal words.
module onehot_dec_skid
  import onehot_pkg::*;
#(
  parameter int ONEHOT_WIDTH = ONEHOT_W,
  parameter int BIN_WIDTH    = BIN_W,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [ONEHOT_WIDTH-1:0] onehot_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [BIN_WIDTH-1:0]    bin_o,
  output logic                    err_o,
  input  logic                    clr_i,
  output logic [CNT_WIDTH-1:0]    err_cnt_o
);

`ifdef ONEHOT_DEC_STRICT_EN
  localparam logic STRICT_EN = 1'b1;
`else
  localparam logic STRICT_EN = 1'b0;
`endif

  dec_state_t           state_q, state_d;
  logic                 ready_q, ready_d;
  logic                 valid_q, valid_d;
  logic [BIN_WIDTH-1:0] out_bin_q, out_bin_d;
  logic                 out_err_q, out_err_d;
  logic [BIN_WIDTH-1:0] skid_bin_q, skid_bin_d;
  logic                 skid_err_q, skid_err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [BIN_WIDTH-1:0] dec_bin;
  logic                 dec_err;
  logic                 in_xfer, out_xfer, load;

  onehot_dec_core #(
    .ONEHOT_WIDTH (ONEHOT_WIDTH),
    .BIN_WIDTH    (BIN_WIDTH)
  ) u_core (
    .onehot_i (onehot_i),
    .bin_o    (dec_bin),
    .err_o    (dec_err)
  );

  assign in_xfer  = valid_i & ready_q;
  assign out_xfer = valid_q & ready_i;
  assign load     = in_xfer & ~(STRICT_EN & dec_err);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    out_bin_d  = out_bin_q;
    out_err_d  = out_err_q;
    skid_bin_d = skid_bin_q;
    skid_err_d = skid_err_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      EMPTY: begin
        if (load) begin
          out_bin_d = dec_bin;
          out_err_d = dec_err;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (load && !out_xfer) begin
          skid_bin_d = dec_bin;
          skid_err_d = dec_err;
          state_d    = FULL;
        end else if (load) begin
          out_bin_d = dec_bin;
          out_err_d = dec_err;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          out_bin_d = skid_bin_q;
          out_err_d = skid_err_q;
          state_d   = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Handshake flags follow the next state so both leave the block as flops.
    ready_d = (state_d != FULL);
    valid_d = (state_d != EMPTY);

    if (clr_i) begin
      cnt_d = '0;
    end else if (in_xfer && dec_err && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state updates use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n_i) begin
      state_q    <= EMPTY;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      out_bin_q  <= '0;
      out_err_q  <= 1'b0;
      skid_bin_q <= '0;
      skid_err_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      out_bin_q  <= out_bin_d;
      out_err_q  <= out_err_d;
      skid_bin_q <= skid_bin_d;
      skid_err_q <= skid_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ready_o   = ready_q;
  assign valid_o   = valid_q;
  assign bin_o     = out_bin_q;
  assign err_cnt_o = cnt_q;
`ifdef ONEHOT_DEC_STRICT_EN
  assign err_o     = 1'b0;
`else
  assign err_o     = out_err_q;
`endif

endmodule

// File: tb/tb_onehot_dec_skid.sv
// Bench for onehot_dec_skid: directed phases plus random traffic, checked
// against a queue-based model of a 2-deep in-order buffer.
module tb_onehot_dec_skid;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] onehot_i;
  logic        valid_o;
  logic        ready_i;
  logic [3:0]  bin_o;
  logic        err_o;
  logic        clr_i;
  logic [7:0]  err_cnt_o;

  onehot_dec_skid dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .onehot_i  (onehot_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .bin_o     (bin_o),
    .err_o     (err_o),
    .clr_i     (clr_i),
    .err_cnt_o (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] bin;
    logic       err;
  } res_t;

  res_t q[$];
  int   m_cnt;
  bit   m_known;
  int   total;
  int   bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t ref_decode(input logic [15:0] w);
    res_t r;
    r.bin = 4'd0;
    r.err = ($countones(w) != 1);
    for (int i = 0; i < 16; i++) begin
      if (w[i]) begin
        r.bin = i[3:0];
        break;
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    case ($urandom_range(0, 3))
      0:       w = 16'h0000;
      1:       w = 16'($urandom);
      default: w = 16'h0001 << $urandom_range(0, 15);
    endcase
    return w;
  endfunction

  // Compare outputs with the model, then advance one clock and update it.
  task automatic step();
    bit   in_x, out_x;
    res_t r;
    if (m_known) begin
      check("ready_o", 32'(ready_o), 32'(q.size() < 2));
      check("valid_o", 32'(valid_o), 32'(q.size() > 0));
      check("err_cnt_o", 32'(err_cnt_o), 32'(m_cnt));
      if (q.size() > 0) begin
        check("bin_o", 32'(bin_o), 32'(q[0].bin));
`ifdef ONEHOT_DEC_STRICT_EN
        check("err_o", 32'(err_o), 32'(0));
`else
        check("err_o", 32'(err_o), 32'(q[0].err));
`endif
      end
    end
    in_x  = valid_i && (q.size() < 2);
    out_x = (q.size() > 0) && ready_i;
    r     = ref_decode(onehot_i);
    @(posedge clk_i);
    if (!rst_n_i) begin
      q.delete();
      m_cnt   = 0;
      m_known = 1'b1;
    end else if (m_known) begin
      if (out_x) void'(q.pop_front());
`ifdef ONEHOT_DEC_STRICT_EN
      if (in_x && !r.err) q.push_back(r);
`else
      if (in_x) q.push_back(r);
`endif
      if (clr_i) m_cnt = 0;
      else if (in_x && r.err && m_cnt < 255) m_cnt++;
    end
    #1;
  endtask

  initial begin
    int          acc;
    bit          tog;
    bit          took;
    logic [15:0] w;
    total    = 0;
    bad      = 0;
    m_cnt    = 0;
    m_known  = 1'b0;
    rst_n_i  = 1'b0;
    valid_i  = 1'b0;
    onehot_i = 16'h0000;
    ready_i  = 1'b1;
    clr_i    = 1'b0;

    // Reset held for two cycles.
    step();
    step();
    rst_n_i = 1'b1;
    step();

    // Legal one-hot sweep at full rate.
    for (int k = 0; k < 16; k++) begin
      valid_i  = 1'b1;
      onehot_i = 16'h0001 << k;
      step();
    end
    valid_i = 1'b0;
    step();
    step();

    // Illegal words: none set, two set.
    valid_i  = 1'b1;
    onehot_i = 16'h0000;
    step();
    onehot_i = 16'h0006;
    step();
    valid_i = 1'b0;
    step();
    step();
    check("cnt_after_illegal", 32'(err_cnt_o), 32'd2);

    // Backpressure fills both entries, then drains in order.
    ready_i  = 1'b0;
    valid_i  = 1'b1;
    onehot_i = 16'h0010;
    step();
    onehot_i = 16'h0100;
    step();
    valid_i = 1'b0;
    step();
    check("bp_ready_low", 32'(ready_o), 32'd0);
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Continuous valid_i with ready_i toggling; a word holds until accepted.
    acc = 0;
    tog = 1'b1;
    w   = rand_word();
    while (acc < 20) begin
      valid_i  = 1'b1;
      onehot_i = w;
      ready_i  = tog;
      tog      = ~tog;
      took     = (q.size() < 2);
      step();
      if (took) begin
        acc++;
        w = rand_word();
      end
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Saturation, then clear racing an illegal accept.
    valid_i  = 1'b1;
    onehot_i = 16'h0000;
    for (int i = 0; i < 300; i++) step();
    check("cnt_saturated", 32'(err_cnt_o), 32'd255);
    clr_i = 1'b1;
    step();
    clr_i   = 1'b0;
    valid_i = 1'b0;
    step();
    check("cnt_cleared", 32'(err_cnt_o), 32'd0);
    for (int i = 0; i < 3; i++) step();

    // Reset while both entries are held.
    ready_i  = 1'b0;
    valid_i  = 1'b1;
    onehot_i = 16'h0020;
    step();
    onehot_i = 16'h0003;
    step();
    valid_i = 1'b0;
    rst_n_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    check("rst_full_valid", 32'(valid_o), 32'd0);
    check("rst_full_ready", 32'(ready_o), 32'd1);
    check("rst_full_cnt", 32'(err_cnt_o), 32'd0);
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      valid_i  = ($urandom_range(0, 3) != 0);
      ready_i  = ($urandom_range(0, 2) != 0);
      clr_i    = ($urandom_range(0, 31) == 0);
      onehot_i = rand_word();
      step();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    clr_i   = 1'b0;
    for (int i = 0; i < 4; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
